// File: rtl/gb_intctl_if.sv
// CPU-facing bus of the Game Boy interrupt controller: load/store register
// access plus the intreq/intaddress/intack handshake.
interface gb_intctl_if;
    logic [15:0] address;
    logic [7:0]  wdata;
    logic        load;
    logic        store;
    logic [7:0]  rdata;
    logic        hit;
    logic        intreq;
    logic [15:0] intaddress;
    logic        intack;

    modport master (
        output address, wdata, load, store, intack,
        input  rdata, hit, intreq, intaddress
    );

    modport slave (
        input  address, wdata, load, store, intack,
        output rdata, hit, intreq, intaddress
    );
endinterface

// File: rtl/gb_intctl.sv
// Game Boy interrupt controller: IF/IE registers, rising-edge capture of the
// five source lines and a request/acknowledge FSM towards the CPU.
module gb_intctl #(
    parameter logic [15:0] IF_ADDR    = 16'hFF0F,
    parameter logic [15:0] IE_ADDR    = 16'hFFFF,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] irq_in,
    gb_intctl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_if;
    logic [7:0]  r_ie;
    logic [4:0]  r_irq_prev;
    logic [2:0]  r_vec_idx;
    logic [2:0]  w_vec_idx_next;
    logic [15:0] r_intaddress;
    logic [15:0] w_intaddress_next;

    logic        w_if_sel;
    logic        w_ie_sel;
    logic        w_store_if;
    logic        w_store_ie;
    logic        w_ack;
    logic [4:0]  w_rise;
    logic [4:0]  w_pending;
    logic [4:0]  w_if_next;
    logic        w_win_valid;
    logic [2:0]  w_win_idx;

    assign w_if_sel   = (bus.address == IF_ADDR);
    assign w_ie_sel   = (bus.address == IE_ADDR);
    assign w_store_if = bus.store & w_if_sel;
    assign w_store_ie = bus.store & w_ie_sel;
    assign w_rise     = irq_in & ~r_irq_prev;
    assign w_pending  = r_if & r_ie[4:0];
    assign w_ack      = (r_state == ST_REQ) & bus.intack;

    assign bus.hit   = bus.load & (w_if_sel | w_ie_sel);
    assign bus.rdata = w_if_sel ? {3'b111, r_if} :
                       w_ie_sel ? r_ie : 8'h00;

    // Lowest index wins: scan downwards so the last match is the lowest.
    always_comb begin
        w_win_idx   = 3'd0;
        w_win_valid = |w_pending;
        for (int i = 4; i >= 0; i--) begin
            if (w_pending[i]) w_win_idx = 3'(i);
        end
    end

    // Applied weakest first so a rising source overrides a write or an ack clear.
    always_comb begin
        w_if_next = r_if;
        if (w_ack)      w_if_next[r_vec_idx] = 1'b0;
        if (w_store_if) w_if_next = bus.wdata[4:0];
        w_if_next = w_if_next | w_rise;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_if       <= 5'h00;
            r_ie       <= 8'h00;
            r_irq_prev <= 5'h00;
        end else begin
            // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
            r_if       <= w_if_next;
            r_irq_prev <= irq_in;
            if (w_store_ie) r_ie <= bus.wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_vec_idx    <= 3'd0;
            r_intaddress <= 16'h0000;
        end else begin
            r_state      <= w_state_next;
            r_vec_idx    <= w_vec_idx_next;
            r_intaddress <= w_intaddress_next;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_state_next      = r_state;
        w_vec_idx_next    = r_vec_idx;
        w_intaddress_next = r_intaddress;
        case (r_state)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_state_next      = ST_REQ;
                    w_vec_idx_next    = w_win_idx;
                    w_intaddress_next = VEC_BASE + VEC_STRIDE * 16'(w_win_idx);
                end
            end
            ST_REQ: begin
                // The vector is frozen here; later, higher-priority sources wait.
                if (bus.intack) begin
                    w_state_next      = ST_GAP;
                    w_intaddress_next = 16'h0000;
                end else if (!w_pending[r_vec_idx]) begin
                    w_state_next      = ST_IDLE;
                    w_intaddress_next = 16'h0000;
                end
            end
            ST_GAP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next      = ST_IDLE;
                w_intaddress_next = 16'h0000;
            end
        endcase
    end

    assign bus.intreq     = (r_state == ST_REQ);
    assign bus.intaddress = r_intaddress;

endmodule

// File: tb/tb_gb_intctl.sv
// Scoreboard bench for gb_intctl: a behavioural model predicts each cycle's
// outputs, a monitor process pops the predictions and compares them.
module tb_gb_intctl;

    localparam logic [15:0] A_IF = 16'hFF0F;
    localparam logic [15:0] A_IE = 16'hFFFF;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] irq_in;

    gb_intctl_if bus();

    gb_intctl dut (
        .clock  (clock),
        .reset  (reset),
        .irq_in (irq_in),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        intreq;
        logic [15:0] intaddress;
        logic        hit;
        logic [7:0]  rdata;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: pending flags, enables, last line levels, source being served
    // (-1 when none) and whether the one-cycle post-ack pause is running.
    logic [4:0] m_if;
    logic [7:0] m_ie;
    logic [4:0] m_prev;
    int         m_serving;
    bit         m_gap;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic bit m_requesting();
        return (m_serving >= 0) && !m_gap;
    endfunction

    task automatic model_reset();
        m_if      = 5'h00;
        m_ie      = 8'h00;
        m_prev    = 5'h00;
        m_serving = -1;
        m_gap     = 1'b0;
    endtask

    task automatic model_edge(input logic [4:0] irq, input logic [15:0] addr,
                              input logic [7:0] wd, input logic st, input logic ack);
        logic [4:0] rise;
        logic [4:0] pend;
        logic [4:0] new_if;
        bit         acked;
        rise  = irq & ~m_prev;
        pend  = m_if & m_ie[4:0];
        acked = m_requesting() && ack;
        for (int i = 0; i < 5; i++) begin
            if (rise[i])                      new_if[i] = 1'b1;
            else if (st && addr == A_IF)      new_if[i] = wd[i];
            else if (acked && i == m_serving) new_if[i] = 1'b0;
            else                              new_if[i] = m_if[i];
        end
        if (m_gap) begin
            m_gap     = 1'b0;
            m_serving = -1;
        end else if (m_requesting()) begin
            if (ack)                     m_gap = 1'b1;
            else if (!pend[m_serving])   m_serving = -1;
        end else if (pend != 5'h00) begin
            for (int i = 4; i >= 0; i--) if (pend[i]) m_serving = i;
        end
        if (st && addr == A_IE) m_ie = wd;
        m_if   = new_if;
        m_prev = irq;
    endtask

    // One clock cycle: drive at the falling edge, predict, then advance the model.
    task automatic step(input logic rst, input logic [4:0] irq, input logic [15:0] addr,
                        input logic [7:0] wd, input logic ld, input logic st, input logic ack);
        exp_t e;
        @(negedge clock);
        reset       = rst;
        irq_in      = irq;
        bus.address = addr;
        bus.wdata   = wd;
        bus.load    = ld;
        bus.store   = st;
        bus.intack  = ack;
        if (rst) model_reset();
        #1;
        e.intreq     = m_requesting();
        e.intaddress = e.intreq ? 16'(64 + 8 * m_serving) : 16'h0000;
        e.hit        = ld && (addr == A_IF || addr == A_IE);
        e.rdata      = (addr == A_IF) ? {3'b111, m_if} : (addr == A_IE) ? m_ie : 8'h00;
        q_exp.push_back(e);
        if (!rst) model_edge(irq, addr, wd, st, ack);
    endtask

    task automatic nop(input logic [4:0] irq, input int n);
        for (int k = 0; k < n; k++) step(1'b0, irq, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] d, input logic [4:0] irq = 5'h00);
        step(1'b0, irq, addr, d, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [4:0] irq = 5'h00);
        step(1'b0, irq, addr, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_ack(input logic [4:0] irq = 5'h00);
        step(1'b0, irq, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            while (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                check("intreq", 32'(bus.intreq), 32'(e.intreq));
                check("intaddress", 32'(bus.intaddress), 32'(e.intaddress));
                check("hit", 32'(bus.hit), 32'(e.hit));
                if (e.hit) check("rdata", 32'(bus.rdata), 32'(e.rdata));
            end
        end
    end

    initial begin : stimulus
        logic [4:0]  irq;
        logic [15:0] addr;
        int          r;
        reset = 1'b1;
        irq_in = 5'h00;
        bus.address = 16'h0000;
        bus.wdata = 8'h00;
        bus.load = 1'b0;
        bus.store = 1'b0;
        bus.intack = 1'b0;
        model_reset();
        step(1'b1, 5'h00, A_IF, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 5'h00, A_IE, 8'h00, 1'b1, 1'b0, 1'b0);
        rd(A_IF);
        rd(A_IE);

        // Single source, vector 0x0050
        wr(A_IE, 8'h04);
        nop(5'h04, 1);
        rd(A_IF);
        nop(5'h00, 2);
        do_ack();
        nop(5'h00, 3);
        rd(A_IF);

        // Priority between simultaneous sources 1 and 4
        wr(A_IE, 8'h1F);
        nop(5'h12, 1);
        nop(5'h00, 2);
        rd(A_IF);
        do_ack();
        nop(5'h00, 2);
        rd(A_IF);
        do_ack();
        nop(5'h00, 2);
        rd(A_IF);

        // No re-vector while a request is presented
        nop(5'h08, 1);
        nop(5'h00, 2);
        nop(5'h01, 1);
        nop(5'h00, 3);
        do_ack();
        nop(5'h00, 4);
        do_ack();
        nop(5'h00, 3);

        // Cancel by clearing IF, then by clearing IE
        nop(5'h02, 1);
        nop(5'h00, 2);
        wr(A_IF, 8'h00);
        nop(5'h00, 3);
        nop(5'h02, 1);
        nop(5'h00, 2);
        wr(A_IE, 8'h00);
        nop(5'h00, 3);
        wr(A_IF, 8'h00);
        wr(A_IE, 8'h1F);

        // Rise collides with IF write, then with the ack of the same bit
        wr(A_IF, 8'h00, 5'h04);
        rd(A_IF);
        nop(5'h00, 1);
        do_ack(5'h04);
        nop(5'h00, 3);
        rd(A_IF);
        do_ack();
        nop(5'h00, 2);

        // Level-held source is captured once
        nop(5'h01, 4);
        do_ack(5'h01);
        nop(5'h01, 5);
        rd(A_IF, 5'h01);
        nop(5'h00, 2);
        nop(5'h01, 1);
        nop(5'h00, 2);
        do_ack();
        nop(5'h00, 2);

        // Asynchronous reset in the middle of a request
        nop(5'h08, 1);
        nop(5'h00, 2);
        step(1'b1, 5'h00, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'h00, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        rd(A_IF);
        rd(A_IE);

        // Randomised traffic
        irq = 5'h00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 1) == 0)
                irq = 5'($urandom & $urandom & $urandom);
            r = $urandom_range(0, 999);
            case ($urandom_range(0, 3))
                0: addr = A_IF;
                1: addr = A_IE;
                2: addr = 16'($urandom);
                default: addr = {8'hFF, 8'($urandom)};
            endcase
            if (r < 3)
                step(1'b1, irq, addr, 8'h00, 1'b0, 1'b0, 1'b0);
            else if (r < 80)
                step(1'b0, irq, A_IF, 8'($urandom), 1'b0, 1'b1, 1'b0);
            else if (r < 140)
                step(1'b0, irq, A_IE, 8'($urandom), 1'b0, 1'b1, 1'b0);
            else if (r < 180)
                step(1'b0, irq, addr, 8'($urandom), 1'b0, 1'b1, 1'b0);
            else if (m_requesting() && r < 500)
                step(1'b0, irq, addr, 8'h00, 1'($urandom), 1'b0, 1'b1);
            else if (r < 230)
                step(1'b0, irq, addr, 8'h00, 1'b0, 1'b0, 1'b1);
            else
                step(1'b0, irq, addr, 8'h00, 1'($urandom), 1'b0, 1'b0);
        end
        nop(5'h00, 2);

        @(negedge clock);
        #3;
        check("scoreboard drained", 32'(q_exp.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
